// File: rtl/pzcorebus_pkg.sv
// pzcorebus_pkg: shared types for the corebus count window sampler.
package pzcorebus_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pzcorebus_window_sampler_state;
endpackage

// File: rtl/pzcorebus_window_timer.sv
// pzcorebus_window_timer: loadable window down-counter flagging its zero (terminal) cycle.
module pzcorebus_window_timer #(
  parameter int WINDOW_WIDTH = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_load,
  input  logic [WINDOW_WIDTH-1:0] i_load_value,
  input  logic                    i_enable,
  output logic                    o_terminal
);
  logic [WINDOW_WIDTH-1:0] timer_q, timer_d;
  always_comb timer_d = i_load ? i_load_value : i_enable ? timer_q - WINDOW_WIDTH'(1) : timer_q;
  always_ff @(posedge i_clk) timer_q <= !i_rst_n ? '0 : timer_d;
  assign o_terminal = timer_q == '0;
endmodule

// File: rtl/pzcorebus_count_window_sampler.sv
// pzcorebus_count_window_sampler: per-window command-count delta with max/min stats and sticky alarm.
// Min tracking is built only when PZCOREBUS_COUNT_WINDOW_SAMPLER_MIN_EN is defined; otherwise o_min is '0.
module pzcorebus_count_window_sampler
  import pzcorebus_pkg::*;
#(
  parameter int COUNT_WIDTH  = 8,
  parameter int WINDOW_WIDTH = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_stop,
  input  logic [WINDOW_WIDTH-1:0] i_window,
  input  logic [COUNT_WIDTH-1:0]  i_threshold,
  input  logic [COUNT_WIDTH-1:0]  i_count,
  output logic                    o_busy,
  output logic                    o_sample_valid,
  output logic [COUNT_WIDTH-1:0]  o_sample,
  output logic [COUNT_WIDTH-1:0]  o_max,
  output logic [COUNT_WIDTH-1:0]  o_min,
  output logic                    o_over
);
  pzcorebus_window_sampler_state state_q, state_d;
  logic [COUNT_WIDTH-1:0]  base_q, base_d, sample_q, sample_d, max_q, max_d, delta;
  logic [WINDOW_WIDTH-1:0] len_q, len_d;
  logic                    valid_q, valid_d, over_q, over_d, load, terminal;
`ifdef PZCOREBUS_COUNT_WINDOW_SAMPLER_MIN_EN
  logic [COUNT_WIDTH-1:0]  min_q, min_d;
`endif
  pzcorebus_window_timer #(.WINDOW_WIDTH(WINDOW_WIDTH)) u_timer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_load       (load),
    .i_load_value (state_q == IDLE ? i_window : len_q),
    .i_enable     (state_q == RUN),
    .o_terminal   (terminal)
  );
  // Modular subtraction absorbs a single wrap of the upstream counter.
  assign delta = i_count - base_q;
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    max_d    = max_q;
    over_d   = over_q;
    load     = 1'b0;
`ifdef PZCOREBUS_COUNT_WINDOW_SAMPLER_MIN_EN
    min_d    = min_q;
`endif
    if (state_q == IDLE) begin
      if (i_start && !i_stop) begin
        state_d = RUN;
        base_d  = i_count;
        len_d   = i_window;
        load    = 1'b1;
        max_d   = '0;
        over_d  = 1'b0;
`ifdef PZCOREBUS_COUNT_WINDOW_SAMPLER_MIN_EN
        min_d   = '1;
`endif
      end
    end else if (i_stop) begin
      state_d = IDLE;
    end else if (terminal) begin
      sample_d = delta;
      base_d   = i_count;
      load     = 1'b1;
      valid_d  = 1'b1;
      max_d    = delta > max_q ? delta : max_q;
      over_d   = over_q | (delta > i_threshold);
`ifdef PZCOREBUS_COUNT_WINDOW_SAMPLER_MIN_EN
      min_d    = delta < min_q ? delta : min_q;
`endif
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      max_q    <= '0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      max_q    <= max_d;
      over_q   <= over_d;
    end
  end
`ifdef PZCOREBUS_COUNT_WINDOW_SAMPLER_MIN_EN
  always_ff @(posedge i_clk) min_q <= !i_rst_n ? '1 : min_d;
  assign o_min = min_q;
`else
  assign o_min = '0;
`endif
  assign o_busy         = state_q == RUN;
  assign o_sample_valid = valid_q;
  assign o_sample       = sample_q;
  assign o_max          = max_q;
  assign o_over         = over_q;
endmodule

// File: tb/tb_pzcorebus_count_window_sampler.sv
// tb_pzcorebus_count_window_sampler: directed plus random checks against a window-accumulator model.
module tb_pzcorebus_count_window_sampler;
  localparam int CW = 8;
  localparam int WW = 16;
  logic          clk = 1'b0;
  logic          rst_n, start, stop;
  logic [WW-1:0] window;
  logic [CW-1:0] thr, cnt;
  logic          busy, valid, over;
  logic [CW-1:0] sample, max_v, min_v;
  int n_checks = 0;
  int n_fail = 0;
  bit m_run, m_valid, m_over;
  int m_len, m_el, m_acc, m_sample, m_max, m_min;
  pzcorebus_count_window_sampler #(.COUNT_WIDTH(CW), .WINDOW_WIDTH(WW)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_stop         (stop),
    .i_window       (window),
    .i_threshold    (thr),
    .i_count        (cnt),
    .o_busy         (busy),
    .o_sample_valid (valid),
    .o_sample       (sample),
    .o_max          (max_v),
    .o_min          (min_v),
    .o_over         (over)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // Model: a window closes after len+1 RUN cycles; its sample is the sum of the
  // increments applied in those cycles, reduced modulo 2^CW.
  task automatic step(bit r, bit st, bit sp, int inc);
    int d;
    rst_n = r;
    start = st;
    stop  = sp;
    cnt   = cnt + CW'(inc);
    @(posedge clk);
    m_valid = 0;
    if (!r) begin
      m_run = 0; m_sample = 0; m_max = 0; m_min = 255; m_over = 0;
    end else if (!m_run) begin
      if (st && !sp) begin
        m_run = 1; m_len = int'(window); m_el = 0; m_acc = 0;
        m_max = 0; m_min = 255; m_over = 0;
      end
    end else if (sp) begin
      m_run = 0;
    end else begin
      m_acc += inc;
      m_el++;
      if (m_el == m_len + 1) begin
        d = m_acc % 256;
        m_valid = 1; m_sample = d;
        if (d > m_max) m_max = d;
        if (d < m_min) m_min = d;
        if (d > int'(thr)) m_over = 1;
        m_el = 0; m_acc = 0;
      end
    end
    #1;
    check("busy", busy, int'(m_run));
    check("valid", valid, int'(m_valid));
    check("sample", sample, m_sample);
    check("max", max_v, m_max);
    check("over", over, int'(m_over));
`ifdef PZCOREBUS_COUNT_WINDOW_SAMPLER_MIN_EN
    check("min", min_v, m_min);
`else
    check("min", min_v, 0);
`endif
  endtask
  task automatic run_steps(int n, int inc);
    for (int i = 0; i < n; i++) step(1, 0, 0, inc);
  endtask
  initial begin
    rst_n = 0; start = 0; stop = 0; window = '0; thr = '0; cnt = '0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("rst_sample", sample, 0);
    check("rst_busy", busy, 0);
    // basic rate: 10-cycle windows, +3 per cycle
    window = 16'd9; thr = 8'd40; cnt = '0;
    step(1, 1, 0, 0);
    run_steps(10, 3);
    check("basic_valid", valid, 1);
    check("basic_sample", sample, 30);
    run_steps(10, 3);
    check("basic_valid2", valid, 1);
    check("basic_max", max_v, 30);
    check("basic_over", over, 0);
    step(1, 0, 1, 3);
    check("basic_stop_busy", busy, 0);
    // wrap: base 250, 12 commands, ends at 6
    window = 16'd11; cnt = 8'd247;
    step(1, 1, 0, 3);
    run_steps(12, 1);
    check("wrap_cnt", cnt, 6);
    check("wrap_sample", sample, 12);
    step(1, 0, 1, 0);
    // threshold and sticky alarm with 5-cycle windows
    window = 16'd4; thr = 8'd20;
    step(1, 1, 0, 0);
    run_steps(5, 1);
    check("thr_over1", over, 0);
    run_steps(5, 10);
    check("thr_over2", over, 1);
    run_steps(5, 1);
    check("thr_over3", over, 1);
    check("thr_max", max_v, 50);
    // stop on the terminal cycle, then start+stop in IDLE
    run_steps(4, 2);
    step(1, 0, 1, 2);
    check("stopterm_valid", valid, 0);
    check("stopterm_sample", sample, 5);
    step(1, 1, 1, 0);
    check("startstop_busy", busy, 0);
    check("startstop_max", max_v, 50);
    // start while running must not disturb the window phase or stats
    step(1, 1, 0, 0);
    run_steps(2, 30);
    step(1, 1, 0, 30);
    run_steps(2, 30);
    check("restart_ign", valid, 1);
    check("restart_over", over, 1);
    // reset mid-window, then resume
    run_steps(2, 4);
    step(0, 0, 0, 4);
    check("midrst_busy", busy, 0);
    check("midrst_max", max_v, 0);
    step(1, 1, 0, 0);
    run_steps(5, 4);
    check("resume_sample", sample, 20);
    step(1, 0, 1, 0);
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if (!m_run) window = WW'($urandom_range(0, 6));
      thr = CW'($urandom_range(0, 200));
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 40));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pzcorebus_count_window_sampler.md
# pzcorebus_count_window_sampler

Windowed rate sampler placed directly downstream of the per-command corebus counters. Takes a free-running command count, snapshots it every programmable window, and reports the per-window delta. Also keeps running max (and optionally min) statistics and a sticky over-threshold alarm. Used by debug and performance logic to read commands-per-window without software polling of raw counters.

## Interface
Parameters:
- COUNT_WIDTH, 8, width of the input count and of every sample/statistic output
- WINDOW_WIDTH, 16, width of the window-length control

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  reset; synchronous, active-low, sampled on rising i_clk
- i_start  input  1  start sampling; honoured only in IDLE
- i_stop  input  1  stop sampling; return to IDLE
- i_window  input  WINDOW_WIDTH  window length minus one, in cycles; latched on start
- i_threshold  input  COUNT_WIDTH  alarm threshold; compared live
- i_count  input  COUNT_WIDTH  free-running, wrapping command count from the upstream counter
- o_busy  output  1  high in RUN
- o_sample_valid  output  1  one-cycle pulse per completed window
- o_sample  output  COUNT_WIDTH  delta of last completed window
- o_max  output  COUNT_WIDTH  largest sample since start
- o_min  output  COUNT_WIDTH  smallest sample since start (see Configuration)
- o_over  output  1  sticky: some sample exceeded i_threshold

## Operation
- FSM states: IDLE, RUN. Reset state IDLE.
- IDLE -> RUN on i_start && !i_stop: base <= i_count, window_len <= i_window, timer <= i_window, o_max <= 0, o_min <= all-ones, o_over <= 0.
- RUN: timer decrements each cycle. Terminal cycle = cycle with timer == 0.
- Terminal cycle: o_sample <= i_count - base (modulo 2^COUNT_WIDTH), base <= i_count, timer <= window_len, o_sample_valid <= 1 for next cycle only.
- Statistics update on the same edge as o_sample: o_max <= max(o_max, delta); o_min <= min(o_min, delta); o_over <= o_over | (delta > i_threshold). Unsigned compares.
- RUN -> IDLE on i_stop. In-progress window is discarded: no sample, no stats update. o_sample, o_max, o_min, o_over hold their values in IDLE.
- i_stop coincident with the terminal cycle: stop wins, no sample.
- i_start && i_stop in IDLE: stay IDLE. i_start in RUN: ignored; no restart, no stats clear.
- Wrap-around: a single wrap of i_count within a window is handled by modular subtraction. More than 2^COUNT_WIDTH-1 commands per window aliases; this is not detected.
- The upstream counter must not be cleared while this block is in RUN. A clear gives a garbage delta for that window only.
- Reset mid-RUN: all state returns to its reset value on the first rising edge with i_rst_n low.
- Reset values: o_busy 0, o_sample_valid 0, o_sample 0, o_max 0, o_min all-ones, o_over 0. Internal: timer 0, base 0, window_len 0.

## Timing
- Window length = i_window + 1 cycles. i_window = 0 gives a sample every cycle.
- First o_sample_valid occurs i_window + 2 cycles after the cycle where i_start is sampled. Later pulses follow every i_window + 1 cycles.
- o_sample, o_max, o_min, o_over change on the same edge that raises o_sample_valid.
- o_busy rises the cycle after i_start and falls the cycle after i_stop.
- Every output is registered. No combinational path from inputs to outputs.

## Configuration
- Macro: PZCOREBUS_COUNT_WINDOW_SAMPLER_MIN_EN.
- Defined: min tracking is implemented as described above.
- Undefined: no min register exists. o_min is tied to '0 and the port is kept for interface stability.

## Structure
- pzcorebus_pkg holds the state enum typedef pzcorebus_window_sampler_state (IDLE, RUN).
- Sub-module pzcorebus_window_timer holds the down-counter.
  - Inputs: load, load value, enable.
  - Outputs: terminal flag (timer == 0).
  - Parameterised by WINDOW_WIDTH.
- Delta, statistics and FSM live in the top module.

## Test plan
- Basic rate: i_window=9, i_count +3 per cycle from 0 -> o_sample_valid every 10 cycles, o_sample=30, o_max=30, o_over=0 with i_threshold=40.
- Wrap: COUNT_WIDTH=8, base=250, 12 commands in the window -> o_sample=12 (i_count ends at 6).
- Threshold and sticky: windows of 5, 50, 5 with i_threshold=20 -> o_over rises with the second sample and stays 1 through the third; o_max=50; o_min=5 with macro, 0 without.
- Stop at terminal: i_stop asserted exactly on the timer==0 cycle -> no o_sample_valid, previous o_sample held, o_busy=0 next cycle.
- Start ignored in RUN, and start+stop in IDLE -> stats not cleared, timer phase unchanged; block remains in IDLE.
- Synchronous reset mid-window (i_rst_n low one cycle) -> all outputs at reset values next cycle, no sample pulse; a fresh i_start resumes normal windows.
